// File: rtl/trace_pkg.sv
// Shared definitions for the trace replayer: entry opcodes, FSM states,
// default field widths and the width helper used to size a trace entry.
// The trace generator script uses the same encodings.
package trace_pkg;

    // Entry opcode, held in the top two bits of every ROM word
    localparam int OP_BITS = 2;

    typedef enum logic [OP_BITS-1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_END  = 2'b11
    } op_e;

    // Replay FSM states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_PUSH  = 3'd2,
        S_POP   = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // Default field widths
    localparam int PTW_DEF       = 16;
    localparam int MTW_DEF       = 16;
    localparam int TREE_NUM_DEF  = 4;
    localparam int ROM_SIZE_DEF  = 8;
    localparam int IDLECYCLE_DEF = 1024;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Entry width: the wider of the idle payload and the push payload, plus the opcode
    function automatic int trace_data_bits(input int ptw, input int mtw,
                                           input int tree_bits, input int idle_bits);
        return max2(idle_bits, 2 * ptw + tree_bits + mtw) + OP_BITS;
    endfunction

endpackage

// File: rtl/trace_entry_decode.sv
// Combinational slicer for one trace ROM entry. Every field is extracted
// unconditionally; the opcode tells the consumer which ones are meaningful.
// Push layout (LSB first): data, meta, tree_id, prio.
module trace_entry_decode
    import trace_pkg::*;
#(
    parameter int PTW             = PTW_DEF,
    parameter int MTW             = MTW_DEF,
    parameter int TREE_NUM_BITS   = 2,
    parameter int IDLECYCLE_BITS  = 10,
    parameter int TRACE_DATA_BITS = 52
) (
    input  logic [TRACE_DATA_BITS-1:0] entry_i,
    output op_e                        op_o,
    output logic [PTW-1:0]             prio_o,
    output logic [TREE_NUM_BITS-1:0]   tree_id_o,
    output logic [MTW-1:0]             meta_o,
    output logic [PTW-1:0]             data_o,
    output logic [TREE_NUM_BITS-1:0]   pop_tree_id_o,
    output logic [IDLECYCLE_BITS-1:0]  idle_o
);

    localparam int META_LSB = PTW;
    localparam int TREE_LSB = PTW + MTW;
    localparam int PRIO_LSB = PTW + MTW + TREE_NUM_BITS;

    // Slice all fields out of the raw entry
    always_comb begin
        op_o          = op_e'(entry_i[TRACE_DATA_BITS-1 -: OP_BITS]);
        data_o        = entry_i[PTW-1:0];
        meta_o        = entry_i[META_LSB +: MTW];
        tree_id_o     = entry_i[TREE_LSB +: TREE_NUM_BITS];
        prio_o        = entry_i[PRIO_LSB +: PTW];
        pop_tree_id_o = entry_i[TREE_NUM_BITS-1:0];
        idle_o        = entry_i[IDLECYCLE_BITS-1:0];
    end

endmodule

// File: rtl/trace_player.sv
// Trace ROM replayer. Walks the ROM from address 0 on a start pulse and turns
// each entry into a push (held until accepted), a pop request (held until
// accepted) or an idle gap. Stops at an END entry or after the last address;
// the address never wraps.
//
// Handshake: o_push/o_pop are valid signals whose fields stay stable until the
// cycle the matching ready is high; the transfer happens on that clock edge.
// Ready inputs are ignored while the matching valid is low.
module trace_player
    import trace_pkg::*;
#(
    parameter int PTW       = PTW_DEF,
    parameter int MTW       = MTW_DEF,
    parameter int TREE_NUM  = TREE_NUM_DEF,
    parameter int ROM_SIZE  = ROM_SIZE_DEF,
    parameter int IDLECYCLE = IDLECYCLE_DEF,
    localparam int TREE_NUM_BITS   = $clog2(TREE_NUM),
    localparam int ROM_WIDTH       = $clog2(ROM_SIZE),
    localparam int IDLECYCLE_BITS  = $clog2(IDLECYCLE),
    localparam int TRACE_DATA_BITS = trace_data_bits(PTW, MTW, TREE_NUM_BITS, IDLECYCLE_BITS)
) (
    input  logic                       i_clk,
    input  logic                       i_srst,
    input  logic                       i_start,
    output logic                       o_rom_read_en,
    output logic [ROM_WIDTH-1:0]       o_rom_addr,
    input  logic [TRACE_DATA_BITS-1:0] i_rom_data,
    output logic                       o_push,
    input  logic                       i_push_ready,
    output logic [PTW-1:0]             o_push_prio,
    output logic [TREE_NUM_BITS-1:0]   o_push_tree_id,
    output logic [MTW-1:0]             o_push_meta,
    output logic [PTW-1:0]             o_push_data,
    output logic                       o_pop,
    input  logic                       i_pop_ready,
    output logic [TREE_NUM_BITS-1:0]   o_pop_tree_id,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [ROM_WIDTH:0]         o_push_cnt
);

    localparam logic [ROM_WIDTH-1:0] LAST_ADDR = ROM_WIDTH'(ROM_SIZE - 1);
    localparam logic [ROM_WIDTH:0]   CNT_MAX   = '1;

    state_e                      state_q, state_d;
    logic [ROM_WIDTH-1:0]        addr_q;
    logic [IDLECYCLE_BITS-1:0]   idle_cnt_q;
    logic [ROM_WIDTH:0]          push_cnt_q;
    logic [PTW-1:0]              prio_q;
    logic [TREE_NUM_BITS-1:0]    tree_id_q;
    logic [MTW-1:0]              meta_q;
    logic [PTW-1:0]              data_q;
    logic [TREE_NUM_BITS-1:0]    pop_tree_id_q;
    logic                        advance;
    logic                        at_last;
    logic                        start_ok;

    op_e                         dec_op;
    logic [PTW-1:0]              dec_prio;
    logic [TREE_NUM_BITS-1:0]    dec_tree_id;
    logic [MTW-1:0]              dec_meta;
    logic [PTW-1:0]              dec_data;
    logic [TREE_NUM_BITS-1:0]    dec_pop_tree_id;
    logic [IDLECYCLE_BITS-1:0]   dec_idle;

    // The ROM answers in the same cycle, so the entry is decoded straight off the bus
    trace_entry_decode #(
        .PTW             (PTW),
        .MTW             (MTW),
        .TREE_NUM_BITS   (TREE_NUM_BITS),
        .IDLECYCLE_BITS  (IDLECYCLE_BITS),
        .TRACE_DATA_BITS (TRACE_DATA_BITS)
    ) u_decode (
        .entry_i       (i_rom_data),
        .op_o          (dec_op),
        .prio_o        (dec_prio),
        .tree_id_o     (dec_tree_id),
        .meta_o        (dec_meta),
        .data_o        (dec_data),
        .pop_tree_id_o (dec_pop_tree_id),
        .idle_o        (dec_idle)
    );

    assign at_last  = (addr_q == LAST_ADDR);
    assign start_ok = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_srst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; 'advance' means the current entry is finished
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) state_d = S_FETCH;
            end
            S_FETCH: begin
                case (dec_op)
                    OP_PUSH: state_d = S_PUSH;
                    OP_POP:  state_d = S_POP;
                    OP_IDLE: begin
                        if (dec_idle != '0) state_d = S_WAIT;
                        else                advance = 1'b1;
                    end
                    default: state_d = S_DONE;
                endcase
            end
            S_PUSH:  advance = i_push_ready;
            S_POP:   advance = i_pop_ready;
            S_WAIT:  advance = (idle_cnt_q <= IDLECYCLE_BITS'(1));
            default: state_d = S_IDLE;
        endcase
        if (advance) state_d = at_last ? S_DONE : S_FETCH;
    end

    // Address, idle counter, push counter and latched entry fields
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            addr_q        <= '0;
            idle_cnt_q    <= '0;
            push_cnt_q    <= '0;
            prio_q        <= '0;
            tree_id_q     <= '0;
            meta_q        <= '0;
            data_q        <= '0;
            pop_tree_id_q <= '0;
        end else begin
            if (start_ok) begin
                addr_q     <= '0;
                push_cnt_q <= '0;
            end
            if (state_q == S_FETCH) begin
                prio_q        <= dec_prio;
                tree_id_q     <= dec_tree_id;
                meta_q        <= dec_meta;
                data_q        <= dec_data;
                pop_tree_id_q <= dec_pop_tree_id;
                idle_cnt_q    <= dec_idle;
            end
            if ((state_q == S_WAIT) && (idle_cnt_q != '0)) begin
                idle_cnt_q <= idle_cnt_q - IDLECYCLE_BITS'(1);
            end
            if ((state_q == S_PUSH) && i_push_ready && (push_cnt_q != CNT_MAX)) begin
                push_cnt_q <= push_cnt_q + (ROM_WIDTH+1)'(1);
            end
            if (advance && !at_last) begin
                addr_q <= addr_q + ROM_WIDTH'(1);
            end
        end
    end

    // Outputs decoded from the current state and latched entry
    always_comb begin
        o_rom_read_en  = (state_q == S_FETCH);
        o_push         = (state_q == S_PUSH);
        o_pop          = (state_q == S_POP);
        o_busy         = (state_q != S_IDLE) && (state_q != S_DONE);
        o_done         = (state_q == S_DONE);
        o_rom_addr     = addr_q;
        o_push_prio    = prio_q;
        o_push_tree_id = tree_id_q;
        o_push_meta    = meta_q;
        o_push_data    = data_q;
        o_pop_tree_id  = pop_tree_id_q;
        o_push_cnt     = push_cnt_q;
    end

endmodule

// File: tb/tb_trace_player.sv
// Bench for trace_player: a bench-owned ROM array feeds the DUT, expected
// push/pop transactions are queued when a trace is loaded and matched when
// the DUT completes a handshake.
module tb_trace_player;

    localparam int PTW  = 16;
    localparam int MTW  = 16;
    localparam int TNB  = 2;
    localparam int RW   = 3;
    localparam int TDB  = 52;
    localparam int PUSHW = 2 * PTW + TNB + MTW;

    logic             clk = 1'b0;
    logic             srst;
    logic             start;
    logic             rom_read_en;
    logic [RW-1:0]    rom_addr;
    logic [TDB-1:0]   rom_data;
    logic             push;
    logic             push_ready;
    logic [PTW-1:0]   push_prio;
    logic [TNB-1:0]   push_tree_id;
    logic [MTW-1:0]   push_meta;
    logic [PTW-1:0]   push_data;
    logic             pop;
    logic             pop_ready;
    logic [TNB-1:0]   pop_tree_id;
    logic             busy;
    logic             done;
    logic [RW:0]      push_cnt;

    logic [TDB-1:0]   rom [0:7];
    logic [PUSHW-1:0] exp_push_q[$];
    logic [TNB-1:0]   exp_pop_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int push_acc = 0;
    int pop_acc  = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    trace_player dut (
        .i_clk          (clk),
        .i_srst         (srst),
        .i_start        (start),
        .o_rom_read_en  (rom_read_en),
        .o_rom_addr     (rom_addr),
        .i_rom_data     (rom_data),
        .o_push         (push),
        .i_push_ready   (push_ready),
        .o_push_prio    (push_prio),
        .o_push_tree_id (push_tree_id),
        .o_push_meta    (push_meta),
        .o_push_data    (push_data),
        .o_pop          (pop),
        .i_pop_ready    (pop_ready),
        .o_pop_tree_id  (pop_tree_id),
        .o_busy         (busy),
        .o_done         (done),
        .o_push_cnt     (push_cnt)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- entry builders ----------------
    function automatic logic [TDB-1:0] e_push(input int p, input int t, input int m, input int d);
        logic [PTW-1:0] pv = PTW'(p);
        logic [TNB-1:0] tv = TNB'(t);
        logic [MTW-1:0] mv = MTW'(m);
        logic [PTW-1:0] dv = PTW'(d);
        return {2'b01, pv, tv, mv, dv};
    endfunction

    function automatic logic [TDB-1:0] e_pop(input int t);
        logic [TNB-1:0] tv = TNB'(t);
        return {2'b10, 48'd0, tv};
    endfunction

    function automatic logic [TDB-1:0] e_idle(input int n);
        logic [9:0] nv = 10'(n);
        return {2'b00, 40'd0, nv};
    endfunction

    function automatic logic [TDB-1:0] e_end();
        return {2'b11, 50'd0};
    endfunction

    function automatic logic [PUSHW-1:0] txn(input int p, input int t, input int m, input int d);
        logic [PTW-1:0] pv = PTW'(p);
        logic [TNB-1:0] tv = TNB'(t);
        logic [MTW-1:0] mv = MTW'(m);
        logic [PTW-1:0] dv = PTW'(d);
        return {pv, tv, mv, dv};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = e_end();
    endtask

    // Queue a push entry in the ROM and its expected transaction
    task automatic load_push(input int a, input int p, input int t, input int m, input int d);
        rom[a] = e_push(p, t, m, d);
        exp_push_q.push_back(txn(p, t, m, d));
    endtask

    // Pulse start; returns in the first S_FETCH cycle
    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check(tag, done, 1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!srst && push && push_ready) begin
            push_acc++;
            if (exp_push_q.size() == 0) check("push_q_nonempty", exp_push_q.size(), 1);
            else check("push_txn", {push_prio, push_tree_id, push_meta, push_data}, exp_push_q.pop_front());
        end
        if (!srst && pop && pop_ready) begin
            pop_acc++;
            if (exp_pop_q.size() == 0) check("pop_q_nonempty", exp_pop_q.size(), 1);
            else check("pop_tree", pop_tree_id, exp_pop_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        logic [PUSHW-1:0] held;

        srst = 1'b1;
        start = 1'b0;
        push_ready = 1'b0;
        pop_ready = 1'b0;
        clear_rom();
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_push", push, 0);
        check("rst_pop", pop, 0);
        check("rst_rden", rom_read_en, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_cnt", push_cnt, 0);
        check("rst_fields", {push_prio, push_tree_id, push_meta, push_data, pop_tree_id}, 0);
        srst = 1'b0;
        step();

        // T1: single push then END, ready always high
        clear_rom();
        load_push(0, 5, 1, 7, 'hAA);
        push_ready = 1'b1;
        start_run();
        check("t1_c1_rden", rom_read_en, 1);
        check("t1_c1_addr", rom_addr, 0);
        check("t1_c1_push", push, 0);
        check("t1_c1_busy", busy, 1);
        step();
        check("t1_c2_push", push, 1);
        check("t1_c2_fields", {push_prio, push_tree_id, push_meta, push_data}, txn(5, 1, 7, 'hAA));
        step();
        check("t1_c3_push", push, 0);
        check("t1_c3_addr", rom_addr, 1);
        check("t1_c3_rden", rom_read_en, 1);
        step();
        check("t1_c4_done", done, 1);
        check("t1_c4_busy", busy, 0);
        check("t1_c4_rden", rom_read_en, 0);
        check("t1_cnt", push_cnt, 1);

        // T2: push held under backpressure
        clear_rom();
        load_push(0, 'h1234, 3, 'h55AA, 'hBEEF);
        push_ready = 1'b0;
        push_acc = 0;
        start_run();
        step();
        held = {push_prio, push_tree_id, push_meta, push_data};
        check("t2_fields", held, txn('h1234, 3, 'h55AA, 'hBEEF));
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_push", push, 1);
            check("t2_hold_fields", {push_prio, push_tree_id, push_meta, push_data}, held);
            step();
        end
        push_ready = 1'b1;
        check("t2_last_push", push, 1);
        step();
        check("t2_released", push, 0);
        wait_done("t2_done", 20);
        check("t2_accepts", push_acc, 1);
        check("t2_cnt", push_cnt, 1);

        // T3a: IDLE n=3 between two pushes
        clear_rom();
        load_push(0, 1, 0, 2, 3);
        rom[1] = e_idle(3);
        load_push(2, 4, 2, 5, 6);
        start_run();
        step();
        check("t3_first_push", push, 1);
        step();
        gap = 0;
        while (!push && gap < 50) begin
            step();
            gap++;
        end
        check("t3_gap_n3", gap, 5);
        wait_done("t3_done", 20);
        check("t3_cnt", push_cnt, 2);

        // T3b: IDLE n=0 adds only its fetch cycle
        clear_rom();
        load_push(0, 7, 1, 8, 9);
        rom[1] = e_idle(0);
        load_push(2, 10, 3, 11, 12);
        start_run();
        step();
        step();
        gap = 0;
        while (!push && gap < 50) begin
            step();
            gap++;
        end
        check("t3_gap_n0", gap, 2);
        wait_done("t3b_done", 20);

        // T4: all pushes, no END; run stops at the last address
        clear_rom();
        push_acc = 0;
        for (int a = 0; a < 8; a++)
            load_push(a, $urandom_range(0, 65535), $urandom_range(0, 3),
                      $urandom_range(0, 65535), $urandom_range(0, 65535));
        start_run();
        wait_done("t4_done", 100);
        check("t4_cnt", push_cnt, 8);
        check("t4_addr", rom_addr, 7);
        repeat (4) step();
        check("t4_addr_hold", rom_addr, 7);
        check("t4_done_hold", done, 1);
        check("t4_accepts", push_acc, 8);

        // T5: pop with delayed ready; start while busy is ignored
        clear_rom();
        rom[0] = e_pop(2);
        exp_pop_q.push_back(2'd2);
        pop_ready = 1'b0;
        pop_acc = 0;
        start_run();
        step();
        check("t5_c2_pop", pop, 1);
        check("t5_c2_tree", pop_tree_id, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5_c3_pop", pop, 1);
        check("t5_c3_busy", busy, 1);
        step();
        pop_ready = 1'b1;
        check("t5_c4_pop", pop, 1);
        step();
        pop_ready = 1'b0;
        check("t5_c5_pop", pop, 0);
        check("t5_c5_addr", rom_addr, 1);
        check("t5_c5_rden", rom_read_en, 1);
        step();
        check("t5_done", done, 1);
        check("t5_accepts", pop_acc, 1);
        check("t5_cnt", push_cnt, 0);

        // T6: reset in the middle of a stalled push, then replay
        clear_rom();
        load_push(0, 'h0F0F, 2, 'h3333, 'h4444);
        push_ready = 1'b0;
        start_run();
        step();
        check("t6_push_pending", push, 1);
        srst = 1'b1;
        step();
        srst = 1'b0;
        exp_push_q.delete();
        check("t6_rst_push", push, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_cnt", push_cnt, 0);
        check("t6_rst_addr", rom_addr, 0);
        exp_push_q.push_back(txn('h0F0F, 2, 'h3333, 'h4444));
        push_ready = 1'b1;
        push_acc = 0;
        start_run();
        check("t6_replay_addr", rom_addr, 0);
        check("t6_replay_rden", rom_read_en, 1);
        wait_done("t6_done", 20);
        check("t6_cnt", push_cnt, 1);
        check("t6_accepts", push_acc, 1);

        step();
        check("end_push_q_empty", exp_push_q.size(), 0);
        check("end_pop_q_empty", exp_pop_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
